// File: rtl/layer1_drain.sv
// Drain stage behind the layer-1 MAC column.
// Counts kernel steps, snapshots the column with bias, saturation and ReLU, then streams lanes out.
module layer1_drain #(
    parameter int LANES = 10,
    parameter int WIDTH = 16,
    parameter int TAPS  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_en,
    input  logic [LANES*WIDTH-1:0]   column,
    input  logic [WIDTH-1:0]         bias,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     col_done,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_WAIT,
        ST_SNAP,
        ST_DRAIN
    } state_t;

    localparam logic [7:0]       TAPS_LAST = 8'(TAPS - 1);
    localparam logic [3:0]       LANE_LAST = 4'(LANES - 1);
    localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_reg, state_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [3:0]         ptr_reg, ptr_next;
    logic               col_done_reg, col_done_next;
    logic               overrun_reg, overrun_next;
    logic [WIDTH-1:0]   lane_reg [LANES];
    logic [WIDTH-1:0]   act [LANES];

    // Per-lane bias add in WIDTH+1 bits, clamp to the signed range, then ReLU.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH:0]   sum;
            logic [WIDTH-1:0] sat;

            assign sum = {column[gi*WIDTH+WIDTH-1], column[gi*WIDTH +: WIDTH]}
                       + {bias[WIDTH-1], bias};

            always_comb begin
                sat = sum[WIDTH-1:0];
                if (sum[WIDTH] != sum[WIDTH-1]) begin
                    sat = sum[WIDTH] ? SAT_MIN : SAT_MAX;
                end
            end

            assign act[gi] = sat[WIDTH-1] ? '0 : sat;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        col_done_next = 1'b0;
        overrun_next  = overrun_reg;
        busy          = (state_reg != ST_ACCUM);
        out_valid     = 1'b0;
        out_idx       = '0;
        out_data      = '0;

        case (state_reg)
            ST_ACCUM: begin
                if (acc_en) begin
                    if (cnt_reg == TAPS_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_WAIT;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            // Covers the MAC output register so the final step is visible on column.
            ST_WAIT: begin
                state_next = ST_SNAP;
            end
            ST_SNAP: begin
                ptr_next   = '0;
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_idx   = ptr_reg;
                out_data  = lane_reg[ptr_reg];
                if (out_ready) begin
                    if (ptr_reg == LANE_LAST) begin
                        ptr_next      = '0;
                        col_done_next = 1'b1;
                        state_next    = ST_ACCUM;
                    end else begin
                        ptr_next = ptr_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase

        // Steps arriving while busy are dropped; only the sticky flag records them.
        if (busy && acc_en) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            col_done_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_reg[i] <= '0;
            end
        end else begin
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
            col_done_reg <= col_done_next;
            overrun_reg  <= overrun_next;
            if (state_reg == ST_SNAP) begin
                for (int i = 0; i < LANES; i++) begin
                    lane_reg[i] <= act[i];
                end
            end
        end
    end

    assign col_done = col_done_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_layer1_drain.sv
// Directed bench for layer1_drain: reset, nominal column, arithmetic corners,
// backpressure, overrun and reset during drain.
module tb_layer1_drain;

    localparam int LANES = 10;
    localparam int WIDTH = 16;
    localparam int TAPS  = 9;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   acc_en;
    logic [LANES*WIDTH-1:0] column;
    logic [WIDTH-1:0]       bias;
    logic [WIDTH-1:0]       out_data;
    logic [3:0]             out_idx;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   col_done;
    logic                   overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] lane_v [LANES];
    logic [15:0] exp_q  [LANES];

    always #5 clk = ~clk;

    layer1_drain #(
        .LANES(LANES),
        .WIDTH(WIDTH),
        .TAPS (TAPS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .acc_en   (acc_en),
        .column   (column),
        .bias     (bias),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .col_done (col_done),
        .overrun  (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_column(input logic [15:0] b);
        for (int i = 0; i < LANES; i++) begin
            column[i*WIDTH +: WIDTH] = lane_v[i];
        end
        bias = b;
    endtask

    task automatic run_taps(input int n);
        for (int i = 0; i < n; i++) begin
            acc_en = 1'b1;
            chk("accum_busy", 32'(busy), 32'd0);
            tick();
        end
        acc_en = 1'b0;
    endtask

    task automatic wait_snap(input logic poke);
        acc_en = poke;
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_valid", 32'(out_valid), 32'd0);
        tick();
        acc_en = 1'b0;
        chk("snap_busy", 32'(busy), 32'd1);
        chk("snap_valid", 32'(out_valid), 32'd0);
        if (poke) chk("overrun_wait", 32'(overrun), 32'd1);
        tick();
    endtask

    task automatic drain(input logic use_bp, input int poke_at, input int stop_after);
        int idx = 0;
        int cyc = 0;
        logic [5:0] pat = 6'b101001;
        while (idx < stop_after && cyc < 200) begin
            out_ready = use_bp ? pat[cyc % 6] : 1'b1;
            acc_en    = (cyc == poke_at);
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_coldone", 32'(col_done), 32'd0);
            chk("out_idx", 32'(out_idx), 32'(idx));
            chk("out_data", 32'(out_data), 32'(exp_q[idx]));
            if (out_ready) idx++;
            cyc++;
            tick();
        end
        acc_en = 1'b0;
        chk("drain_count", 32'(idx), 32'(stop_after));
    endtask

    task automatic finish_col();
        chk("col_done", 32'(col_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        tick();
        chk("col_done_once", 32'(col_done), 32'd0);
    endtask

    task automatic column_case(input logic [15:0] b, input logic bp);
        load_column(b);
        run_taps(TAPS);
        wait_snap(1'b0);
        drain(bp, -1, LANES);
        finish_col();
    endtask

    task automatic nominal(input logic [15:0] b);
        for (int i = 0; i < LANES; i++) begin
            lane_v[i] = 16'(100 * i);
            exp_q[i]  = 16'(100 * i) + b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        acc_en    = 1'b0;
        out_ready = 1'b0;
        column    = '0;
        bias      = '0;
        tick();

        // Reset held with random inputs: every output reads zero.
        for (int r = 0; r < 2; r++) begin
            acc_en    = 1'($urandom);
            out_ready = 1'($urandom);
            column    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            bias      = 16'($urandom);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_coldone", 32'(col_done), 32'd0);
            chk("rst_overrun", 32'(overrun), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_idx", 32'(out_idx), 32'd0);
            tick();
        end

        // First acc_en after release is step 1: 8 steps leave ACCUM in place.
        reset     = 1'b1;
        out_ready = 1'b1;
        nominal(16'd5);
        load_column(16'd5);
        run_taps(TAPS - 1);
        chk("eight_steps_busy", 32'(busy), 32'd0);
        tick();
        chk("eight_steps_busy2", 32'(busy), 32'd0);
        run_taps(1);
        wait_snap(1'b0);
        drain(1'b0, -1, LANES);
        finish_col();

        // Nominal column, nine consecutive steps.
        nominal(16'd5);
        column_case(16'd5, 1'b0);

        // Corner A: positive saturation.
        for (int i = 0; i < LANES; i++) begin lane_v[i] = 16'h0000; exp_q[i] = 16'h0200; end
        lane_v[0] = 16'h7F00; exp_q[0] = 16'h7FFF;
        lane_v[4] = 16'h7E00; exp_q[4] = 16'h7FFF;
        lane_v[5] = 16'hFF00; exp_q[5] = 16'h0100;
        column_case(16'h0200, 1'b0);

        // Corner B: negative result clamps to zero via ReLU.
        for (int i = 0; i < LANES; i++) begin lane_v[i] = 16'h0000; exp_q[i] = 16'h0064; end
        lane_v[0] = 16'd200;  exp_q[0] = 16'h012C;
        lane_v[1] = 16'hFED4; exp_q[1] = 16'h0000;
        lane_v[2] = 16'hFF9C; exp_q[2] = 16'h0000;
        lane_v[3] = 16'h7FFF; exp_q[3] = 16'h7FFF;
        column_case(16'd100, 1'b0);

        // Corner C: negative saturation, then ReLU.
        for (int i = 0; i < LANES; i++) begin lane_v[i] = 16'h0000; exp_q[i] = 16'h0000; end
        lane_v[0] = 16'h0001; exp_q[0] = 16'h0000;
        lane_v[1] = 16'h0002; exp_q[1] = 16'h0001;
        lane_v[2] = 16'h8000; exp_q[2] = 16'h0000;
        lane_v[3] = 16'h7FFF; exp_q[3] = 16'h7FFE;
        column_case(16'hFFFF, 1'b0);

        // Corner D: zero bias passes positives, kills negatives.
        for (int i = 0; i < LANES; i++) begin
            lane_v[i] = 16'(16'h0111 * i);
            exp_q[i]  = 16'(16'h0111 * i);
        end
        lane_v[3] = 16'h0000; exp_q[3] = 16'h0000;
        lane_v[9] = 16'h8001; exp_q[9] = 16'h0000;
        column_case(16'h0000, 1'b0);

        // Backpressure with ready pattern 1,0,0,1,0,1...
        nominal(16'd5);
        column_case(16'd5, 1'b1);

        // Overrun: steps during WAIT and DRAIN are ignored but flagged.
        nominal(16'd7);
        load_column(16'd7);
        chk("overrun_clear", 32'(overrun), 32'd0);
        run_taps(TAPS);
        wait_snap(1'b1);
        drain(1'b0, 3, LANES);
        finish_col();
        chk("overrun_sticky", 32'(overrun), 32'd1);
        run_taps(TAPS - 1);
        chk("ovr_eight_busy", 32'(busy), 32'd0);
        tick();
        chk("ovr_eight_busy2", 32'(busy), 32'd0);
        run_taps(1);
        wait_snap(1'b0);
        drain(1'b0, -1, LANES);
        finish_col();
        chk("overrun_sticky2", 32'(overrun), 32'd1);

        // Reset after lane 4 is accepted discards the column.
        nominal(16'd3);
        load_column(16'd3);
        run_taps(TAPS);
        wait_snap(1'b0);
        drain(1'b0, -1, 5);
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_coldone", 32'(col_done), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        tick();
        chk("mid_rst_coldone2", 32'(col_done), 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        column_case(16'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer1_drain.md
# layer1_drain

Downstream consumer of the 10-lane layer-1 MAC array. It counts the weight/pixel steps applied to the array, snapshots the 160-bit column result once a full kernel has been accumulated, and adds a shared bias with saturation and ReLU. It then streams the 10 activations out one per handshake to the layer-2 input buffer, and asserts `busy` so the upstream feeder stalls while the column is drained.

## Interface
Parameters:
- `LANES`, 10, number of MAC lanes in the column.
- `WIDTH`, 16, width of each lane, signed two's complement.
- `TAPS`, 9, number of accumulation steps per column (kernel size); legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `acc_en`  in  1  the MAC array is accumulating one pixel/weight step this cycle.
- `column`  in  LANES*WIDTH  registered MAC outputs; lane i occupies bits [16i+15:16i].
- `bias`  in  WIDTH  signed bias shared by all lanes; sampled in SNAP.
- `out_data`  out  WIDTH  activation of the current lane.
- `out_idx`  out  4  lane index of `out_data`, 0..LANES-1.
- `out_valid`  out  1  `out_data` and `out_idx` are valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `busy`  out  1  column is being captured or drained; upstream must hold `acc_en` low.
- `col_done`  out  1  one-cycle pulse after the last lane has been accepted.
- `overrun`  out  1  sticky error: `acc_en` was seen while `busy` was high.

## Operation
- The state machine has four states: ACCUM, WAIT, SNAP and DRAIN.
- **ACCUM**
  - A step counter (8 bits) increments on each `acc_en`.
  - On the `acc_en` that makes the count equal to `TAPS`, the next state is WAIT and the counter clears.
- **WAIT**
  - One cycle, covering the MAC output register latency.
  - Next state is SNAP.
- **SNAP**
  - For each lane i: `s = sext17(column_i) + sext17(bias)`.
  - Saturate `s` to the signed 16-bit range [0x8000, 0x7FFF].
  - Apply ReLU: a negative result becomes 0.
  - Store the result in lane register i. Next state is DRAIN with the lane pointer at 0.
- **DRAIN**
  - `out_valid` = 1; `out_data` = lane register[pointer]; `out_idx` = pointer.
  - On `out_valid && out_ready` the pointer increments.
  - When lane LANES-1 is accepted, `col_done` pulses on the next cycle and the state returns to ACCUM.
- `busy` = 1 in WAIT, SNAP and DRAIN.
- `acc_en` while `busy` is high:
  - The counter is unchanged and the step is ignored.
  - `overrun` is set and stays set until reset.
- Reset, including mid-operation:
  - State goes to ACCUM; counter and pointer go to 0; lane registers are cleared.
  - All outputs are 0, including `out_valid`, `busy`, `col_done` and `overrun`.
  - A partially drained column is discarded.

## Timing
- Let cycle T be the cycle in which the `TAPS`-th `acc_en` is sampled.
  - T+1: WAIT, `busy` = 1.
  - T+2: SNAP; `column` and `bias` are sampled.
  - T+3: first `out_valid`.
- With `out_ready` held at 1:
  - Lanes 0..9 are presented on cycles T+3..T+12.
  - `col_done` = 1 on T+13, with `busy` = 0 on the same cycle.
  - `acc_en` is accepted again from T+13.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_idx` hold stable. No lane is skipped or repeated.
- `out_valid` never drops between lanes unless reset is asserted.
- `col_done` is never asserted in the same cycle as `out_valid`.

## Test plan
- **Reset:** assert `reset` = 0 for 2 cycles with random inputs. All outputs must be 0 and the state ACCUM; the first `acc_en` after release must count as step 1.
- **Nominal column:** 9 consecutive `acc_en`; `column` lane i = 100*i; `bias` = 5; `out_ready` = 1.
  - `out_data` must be 5, 105, …, 905 with `out_idx` 0..9 on T+3..T+12.
  - `col_done` = 1 on T+13.
- **Arithmetic corners:**
  - lane0 = 0x7F00, bias = 0x0200 → 0x7FFF.
  - lane1 = -300, bias = 100 → 0.
  - lane2 = 0x8000, bias = 0xFFFF → 0 (saturates to 0x8000, then ReLU).
  - lane3 = 0, bias = 0 → 0.
- **Backpressure:** toggle `out_ready` with the pattern 1,0,0,1,0,1….
  - Exactly 10 transfers occur, with indices 0..9 in order.
  - `out_data` is stable during every stall.
  - `col_done` pulses once, only after the 10th transfer.
- **Overrun:** pulse `acc_en` during WAIT and during DRAIN.
  - `overrun` goes to 1 and stays 1.
  - The drained values are unchanged.
  - The next column still requires exactly 9 `acc_en` pulses.
- **Reset mid-drain:** assert reset after lane 4 is accepted.
  - `out_valid` = 0 the next cycle and no `col_done` is produced.
  - After release, a full column drains starting from `out_idx` 0.
